// File: rtl/serial_subtractor4bit.sv
// serial_subtractor4bit: bit-serial a - b - bin, LSB first, WIDTH cycles.
// Ports: clk, rst, start, a, b, bin -> busy, done, diff, bout; ovf with SUBTRACTOR_OVF_EN.
module serial_subtractor4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sd;

  logic             ai;
  logic             bi;
  logic             di;
  logic             brn;
  logic             last;
  logic [WIDTH-1:0] res;

  assign ai   = sa[0];
  assign bi   = sb[0];
  assign di   = ai ^ bi ^ br;
  assign brn  = (~ai & bi) | (~(ai ^ bi) & br);
  assign last = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res  = {di, sd};
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      br    <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUBTRACTOR_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= res[WIDTH-1:1];
          br  <= brn;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            done  <= 1'b1;
            diff  <= res;
            bout  <= brn;
`ifdef SUBTRACTOR_OVF_EN
            // borrow into the MSB differs from borrow out: signed overflow
            ovf   <= br ^ brn;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
